// File: rtl/ser_add_sched_if.sv
// ser_add_sched_if: requester, response and adder-side signals of the
// serial-adder scheduler.
//   req0_*/req1_*  : operand-pair request channels (valid/ready, a, b)
//   resp_*         : result channel (valid/ready, id, sum)
//   busy           : scheduler not idle
//   sa_mode/sa_a/sa_b/sa_sum : connection to the serial adder
// Modport slave is the scheduler view; master is the client/adder view.
interface ser_add_sched_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_sum;
    logic             busy;
    logic             sa_mode;
    logic [WIDTH-1:0] sa_a;
    logic [WIDTH-1:0] sa_b;
    logic             sa_sum;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready, sa_sum,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, busy,
        output sa_mode, sa_a, sa_b
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready, sa_sum,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, busy,
        input  sa_mode, sa_a, sa_b
    );
endinterface

// File: rtl/ser_add_sched.sv
// ser_add_sched: round-robin two-requester scheduler for a serial adder.
// Grants one operand pair, loads it into the adder (one LOAD cycle), runs
// WIDTH shift cycles collecting the LSB-first sum, then presents the sum and
// requester id on a valid/ready response port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : ser_add_sched_if.slave (requests, response, busy, adder side)
module ser_add_sched #(
    parameter int unsigned WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    ser_add_sched_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic             prio;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             valid_q;
    logic             grant0;
    logic             grant1;

    // Grants are combinational in IDLE; masked while reset is held so no
    // ready appears before the first post-reset cycle.
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
                    grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
                end
                if (grant0 || grant1) state_nx = LOAD;
            end
            LOAD:  state_nx = SHIFT;
            SHIFT: if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
            DONE:  if (bus.resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            prio    <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    // Priority moves to the requester that lost (or was idle).
                    if (grant0) begin
                        a_q  <= bus.req0_a;
                        b_q  <= bus.req0_b;
                        id_q <= 1'b0;
                        prio <= 1'b1;
                    end else if (grant1) begin
                        a_q  <= bus.req1_a;
                        b_q  <= bus.req1_b;
                        id_q <= 1'b1;
                        prio <= 1'b0;
                    end
                end
                LOAD: cnt <= '0;
                SHIFT: begin
                    // LSB arrives first, so shift right and insert at the MSB.
                    result <= {bus.sa_sum, result[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = result;
    assign bus.busy       = (state != IDLE);
    assign bus.sa_mode    = (state != SHIFT);
    assign bus.sa_a       = a_q;
    assign bus.sa_b       = b_q;
endmodule

// File: tb/tb_ser_add_sched.sv
// tb_ser_add_sched: scoreboard bench for ser_add_sched with a behavioural
// serial adder (optionally replaced by a fixed alternating bit pattern).
module tb_ser_add_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ser_add_sched_if #(.WIDTH(W)) bus ();

    ser_add_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Serial adder model: load on sa_mode=1, else shift one bit with carry.
    logic [W-1:0] ma, mb;
    logic         mc;
    int           pat_k = 0;
    bit           use_pat = 0;
    always @(posedge clk) begin
        if (bus.sa_mode) begin
            ma    <= bus.sa_a;
            mb    <= bus.sa_b;
            mc    <= 1'b0;
            pat_k <= 0;
        end else begin
            ma    <= ma >> 1;
            mb    <= mb >> 1;
            mc    <= (ma[0] & mb[0]) | (ma[0] & mc) | (mb[0] & mc);
            pat_k <= pat_k + 1;
        end
    end
    assign bus.sa_sum = use_pat ? pat_k[0] : (ma[0] ^ mb[0] ^ mc);

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
    } exp_t;
    exp_t sb_q[$];
    int   acc_q[$];

    // Monitor: latency, shift-cycle count, response compare, ready rules.
    int   low_cnt = 0;
    logic prev_valid = 1'b0;
    int   viol = 0;
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (reset) begin
            low_cnt    = 0;
            prev_valid = 1'b0;
            if (bus.req0_ready || bus.req1_ready) viol++;
        end else begin
            if (bus.req0_ready && bus.req1_ready) viol++;
            if (bus.busy && (bus.req0_ready || bus.req1_ready)) viol++;
            if (!bus.sa_mode) low_cnt++;
            if (bus.resp_valid && !prev_valid) begin
                check("sa_mode_low_cycles", low_cnt, 16);
                low_cnt = 0;
                if (acc_q.size() == 0) fail("latency_no_accept");
                else begin
                    a = acc_q.pop_front();
                    check("resp_latency", cyc - a, 18);
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb_q.size() == 0) fail("resp_unexpected");
                else begin
                    e = sb_q.pop_front();
                    check("resp_id", bus.resp_id, e.id);
                    check("resp_sum", bus.resp_sum, e.sum);
                end
            end
            prev_valid = bus.resp_valid;
        end
    end

    task automatic push(input logic id, input logic [W-1:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Call away from a clock edge; returns 1ns after the accept edge.
    task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 0;
        set_req(id, 1'b1, a, b);
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
                acc_q.push_back(cyc);
                done = 1;
                @(posedge clk);
                #1;
                set_req(id, 1'b0, a, b);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            fail("grant_timeout");
            set_req(id, 1'b0, a, b);
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && acc_q.size() == 0 && !bus.busy) ok = 1;
        end
        if (!ok) fail("drain_timeout");
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           seen;
        int           k;
        int           unstable;
        logic [W-1:0] s;
        logic         sid;

        bus.resp_ready = 1'b1;
        set_req(1'b0, 1'b1, 16'h0001, 16'h0001);
        set_req(1'b1, 1'b1, 16'h0002, 16'h0002);

        // Reset state with both requesters already valid.
        repeat (3) @(negedge clk);
        #1;
        check("rst_sa_mode", bus.sa_mode, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_sa_a", bus.sa_a, 16'h0000);
        #1;
        reset = 1'b0;

        // Simultaneous requests plus a queued second req0: order 0,1,0.
        push(1'b0, 16'h0002);
        push(1'b1, 16'h0004);
        push(1'b0, 16'h0007);
        fork
            begin
                drive(1'b0, 16'h0001, 16'h0001);
                drive(1'b0, 16'h0003, 16'h0004);
            end
            drive(1'b1, 16'h0002, 16'h0002);
        join
        // Last grant went to 0, so a repeat pair starts with 1.
        push(1'b1, 16'h0300);
        push(1'b0, 16'h0030);
        fork
            drive(1'b0, 16'h0010, 16'h0020);
            drive(1'b1, 16'h0100, 16'h0200);
        join
        wait_drain();

        // Single request.
        push(1'b0, 16'h2345);
        drive(1'b0, 16'h1234, 16'h1111);
        check("sa_a_hold", bus.sa_a, 16'h1234);
        check("sa_b_hold", bus.sa_b, 16'h1111);
        wait_drain();

        // Wrap-around.
        push(1'b1, 16'h0000);
        drive(1'b1, 16'hFFFF, 16'h0001);
        push(1'b1, 16'h0000);
        drive(1'b1, 16'h8000, 16'h8000);
        wait_drain();

        // Back-pressure in DONE with a pending req1.
        bus.resp_ready = 1'b0;
        push(1'b0, 16'h6666);
        drive(1'b0, 16'h5555, 16'h1111);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1;
        end
        if (!seen) fail("bp_wait_valid");
        #2;
        s   = bus.resp_sum;
        sid = bus.resp_id;
        check("bp_sum", s, 16'h6666);
        push(1'b1, 16'h1010);
        unstable = 0;
        fork
            drive(1'b1, 16'h0F0F, 16'h0101);
            begin
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (bus.resp_valid !== 1'b1 || bus.resp_sum !== s || bus.resp_id !== sid ||
                        bus.busy !== 1'b1 || bus.req0_ready || bus.req1_ready) unstable++;
                end
                check("bp_stable", unstable, 0);
                bus.resp_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_release_idle", bus.busy, 0);
            end
        join
        wait_drain();

        // Reset at shift bit 7, with req0 valid during reset.
        drive(1'b0, 16'h1234, 16'h4321);
        k = 0;
        for (int i = 0; i < 100 && k < 8; i++) begin
            @(negedge clk);
            if (!bus.sa_mode) k++;
        end
        if (k < 8) fail("shift_wait");
        #2;
        reset = 1'b1;
        set_req(1'b0, 1'b1, 16'h00FF, 16'h0001);
        #1;
        check("midrst_sa_mode", bus.sa_mode, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_req0_ready", bus.req0_ready, 0);
        acc_q.delete();
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        set_req(1'b0, 1'b0, 16'h00FF, 16'h0001);
        reset = 1'b0;
        #2;
        push(1'b0, 16'h0100);
        drive(1'b0, 16'h00FF, 16'h0001);
        wait_drain();

        // LSB-first assembly: bit k = k mod 2.
        use_pat = 1;
        push(1'b1, 16'hAAAA);
        drive(1'b1, 16'h0000, 16'h0000);
        wait_drain();
        use_pat = 0;

        check("ready_rules", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ser_add_sched.md
# ser_add_sched

Two-requester scheduler and sequencer for the 16-bit serial adder `ser_add`. It arbitrates operand pairs from two requesters round-robin and loads the winner into the adder. It then drives the adder's mode line through one load cycle and WIDTH shift cycles, deserialises the LSB-first sum stream into a parallel result, and returns that result with a requester ID over a valid/ready response port. It sits between the adder and its client logic; the adder holds no handshake state of its own.

## Interface
- WIDTH, 16, operand/result width and number of shift cycles
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that issued the result
- resp_sum  out  WIDTH  (a+b) mod 2^WIDTH
- busy  out  1  high in every state except IDLE
- sa_mode  out  1  to adder: 1 = load operands, 0 = shift one bit
- sa_a, sa_b  out  WIDTH  to adder operand inputs
- sa_sum  in  1  from adder: serial sum bit, LSB first

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - sa_mode=1.
  - Arbitration is combinational from the valid inputs and the priority pointer `prio`.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, requester `prio` is granted.
  - Only the granted requester's ready is high; at most one ready is ever high.
  - On a grant edge: capture the operands into sa_a/sa_b, capture the ID, set `prio` to the non-granted index, go to LOAD.
- LOAD:
  - One cycle with sa_mode=1; the adder captures sa_a/sa_b at the closing edge.
  - Clear the bit counter. Go to SHIFT.
- SHIFT:
  - WIDTH cycles with sa_mode=0.
  - Each edge: shift sa_sum into the MSB of the result register (shift right), increment the counter.
  - After the WIDTH-th sample, go to DONE.
- DONE:
  - resp_valid=1; resp_sum and resp_id are stable until the handshake.
  - sa_mode=1.
  - Go to IDLE at the edge where resp_ready=1.
- All ready outputs are 0 outside IDLE. Requests arriving then are held off, not dropped.
- sa_a/sa_b hold their values through LOAD, SHIFT and DONE. They change only on a grant.
- Arithmetic is modulo 2^WIDTH. Carry-out is discarded; the adder exposes none.
- Reset, asynchronous and valid at any point including mid-SHIFT:
  - FSM to IDLE; any in-flight result is discarded.
  - `prio`=0, counter=0, result=0, sa_a=sa_b=0, resp_id=0.
  - Outputs: sa_mode=1, resp_valid=0, busy=0, req0_ready/req1_ready=0 until the first cycle after reset deasserts.

## Timing
- Grant/accept happens in the IDLE cycle where valid is high: zero-cycle arbitration latency from IDLE.
- Let cycle 0 be the accept edge. Then:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2..WIDTH+1; sa_sum for bit k is sampled at the end of cycle k+2.
  - resp_valid rises in cycle WIDTH+2 (cycle 18 for WIDTH=16).
- Minimum issue interval is WIDTH+3 cycles: IDLE, LOAD, WIDTH×SHIFT, DONE with resp_ready already high.
- resp_ready held low stalls in DONE indefinitely. No new grant is made during the stall.
- resp_valid is registered. The ready outputs are combinational from the valid inputs, `prio` and state.

## Test plan
- Single request: req0 a=0x1234, b=0x1111, model adder correct → resp_sum=0x2345, resp_id=0, resp_valid 18 cycles after accept; sa_mode low for exactly 16 cycles.
- Wrap-around: req1 a=0xFFFF, b=0x0001 → resp_sum=0x0000, resp_id=1. Also a=0x8000, b=0x8000 → 0x0000.
- Simultaneous: both valid from reset with 0x0001+0x0001 (req0) and 0x0002+0x0002 (req1) → first resp_id=0 sum 0x0002, then resp_id=1 sum 0x0004. A repeat pair alternates 0,1; req1_ready never high while req0 is serviced.
- Back-pressure: hold resp_ready=0 for 10 cycles in DONE → resp_valid, resp_sum and resp_id stable, busy=1, no ready asserted; release → IDLE next cycle.
- Reset mid-SHIFT: assert reset at shift bit 7 → immediately sa_mode=1, busy=0, resp_valid=0. After release, a new request 0x00FF+0x0001 returns 0x0100 with correct latency and no stale bits.
- Serial order check: adder model driving a known pattern on sa_sum (bit k = k mod 2) → resp_sum=0xAAAA, confirming LSB-first assembly.
